// File: rtl/mem2_stage_pkg.sv
// Shared CPU definitions for the MEM2 stage: load/write-enable types, writeback select encoding, payload struct.
package mem2_stage_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned WBSEL_W = 2;

    localparam logic [WBSEL_W-1:0] WBSEL_LOAD = 2'b11;

    typedef struct packed {
        logic       sign;
        logic [1:0] size;
        logic       lwl;
        logic       lwr;
    } LoadType;

    typedef struct packed {
        logic cp0;
        logic hi;
        logic lo;
        logic rf;
    } RegsWrType;

    // Passthrough payload carried from MEM1 to WB
    typedef struct packed {
        logic [DATA_W-1:0]  alu_out;
        logic [DATA_W-1:0]  pc;
        logic [DATA_W-1:0]  instr;
        logic [REG_W-1:0]   dst;
        logic [WBSEL_W-1:0] wb_sel;
        LoadType            load_type;
        RegsWrType          regs_wr_type;
        logic [DATA_W-1:0]  out_b;
        logic [DATA_W-1:0]  result;
    } mem2_fields_t;

    function automatic logic is_load(input logic [WBSEL_W-1:0] wb_sel, input RegsWrType rwt);
        return (wb_sel == WBSEL_LOAD) && (rwt != '0);
    endfunction

endpackage

// File: rtl/mem2_stage_if.sv
// MEM1 -> MEM2 -> WB bus plus DCache read response and hazard controls.
interface mem2_stage_if
    import mem2_stage_pkg::*;
#(
    parameter int unsigned STALL_CNT_W = 32
);
    logic                   MEM2_Flush;
    logic                   MEM2_Wr;
    logic [DATA_W-1:0]      MEM1_ALUOut;
    logic [DATA_W-1:0]      MEM1_PC;
    logic [DATA_W-1:0]      MEM1_Instr;
    logic [REG_W-1:0]       MEM1_Dst;
    logic [WBSEL_W-1:0]     MEM1_WbSel;
    LoadType                MEM1_LoadType;
    RegsWrType              MEM1_RegsWrType;
    logic [DATA_W-1:0]      MEM1_OutB;
    logic [DATA_W-1:0]      MEM1_Result;
    logic                   DC_RValid;
    logic [DATA_W-1:0]      DC_RData;

    logic [DATA_W-1:0]      MEM2_ALUOut;
    logic [DATA_W-1:0]      MEM2_PC;
    logic [DATA_W-1:0]      MEM2_Instr;
    logic [DATA_W-1:0]      MEM2_OutB;
    logic [DATA_W-1:0]      MEM2_Result;
    logic [REG_W-1:0]       MEM2_Dst;
    logic [WBSEL_W-1:0]     MEM2_WbSel;
    LoadType                MEM2_LoadType;
    RegsWrType              MEM2_RegsWrType;
    logic [DATA_W-1:0]      MEM2_DMOut;
    logic                   MEM2_Stall_Req;
    logic [STALL_CNT_W-1:0] MEM2_StallCnt;

    modport slave (
        input  MEM2_Flush, MEM2_Wr, MEM1_ALUOut, MEM1_PC, MEM1_Instr, MEM1_Dst, MEM1_WbSel,
               MEM1_LoadType, MEM1_RegsWrType, MEM1_OutB, MEM1_Result, DC_RValid, DC_RData,
        output MEM2_ALUOut, MEM2_PC, MEM2_Instr, MEM2_OutB, MEM2_Result, MEM2_Dst, MEM2_WbSel,
               MEM2_LoadType, MEM2_RegsWrType, MEM2_DMOut, MEM2_Stall_Req, MEM2_StallCnt
    );

    modport master (
        output MEM2_Flush, MEM2_Wr, MEM1_ALUOut, MEM1_PC, MEM1_Instr, MEM1_Dst, MEM1_WbSel,
               MEM1_LoadType, MEM1_RegsWrType, MEM1_OutB, MEM1_Result, DC_RValid, DC_RData,
        input  MEM2_ALUOut, MEM2_PC, MEM2_Instr, MEM2_OutB, MEM2_Result, MEM2_Dst, MEM2_WbSel,
               MEM2_LoadType, MEM2_RegsWrType, MEM2_DMOut, MEM2_Stall_Req, MEM2_StallCnt
    );

endinterface

// File: rtl/mem2_stage_reg.sv
// MEM2 pipeline register for passthrough fields; flush clears, write loads, otherwise hold.
module mem2_reg
    import mem2_stage_pkg::*;
(
    input  logic         clk,
    input  logic         resetn,
    input  logic         i_flush,
    input  logic         i_wr,
    input  mem2_fields_t i_d,
    output mem2_fields_t o_q
);

    mem2_fields_t r_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)      r_q <= '0;
        else if (i_flush) r_q <= '0;
        else if (i_wr)    r_q <= i_d;
    end

    assign o_q = r_q;

endmodule

// File: rtl/mem2_stage.sv
// Second memory stage: stage register, DCache load-wait FSM with stall request,
// load data capture and saturating load-stall counter.
module mem2_stage
    import mem2_stage_pkg::*;
#(
    parameter int unsigned STALL_CNT_W = 32
)(
    input  logic        clk,
    input  logic        resetn,
    mem2_stage_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   w_accept;
    logic                   w_cap_load;
    logic                   w_busy;
    logic [DATA_W-1:0]      r_dmout;
    logic [STALL_CNT_W-1:0] r_stall_cnt;
    mem2_fields_t           w_d;
    mem2_fields_t           w_q;

    always_comb begin
        w_d.alu_out      = bus.MEM1_ALUOut;
        w_d.pc           = bus.MEM1_PC;
        w_d.instr        = bus.MEM1_Instr;
        w_d.dst          = bus.MEM1_Dst;
        w_d.wb_sel       = bus.MEM1_WbSel;
        w_d.load_type    = bus.MEM1_LoadType;
        w_d.regs_wr_type = bus.MEM1_RegsWrType;
        w_d.out_b        = bus.MEM1_OutB;
        w_d.result       = bus.MEM1_Result;
    end

    mem2_reg u_reg (
        .clk     (clk),
        .resetn  (resetn),
        .i_flush (bus.MEM2_Flush),
        .i_wr    (bus.MEM2_Wr),
        .i_d     (w_d),
        .o_q     (w_q)
    );

    assign w_cap_load = bus.MEM2_Wr && !bus.MEM2_Flush && is_load(bus.MEM1_WbSel, bus.MEM1_RegsWrType);
    assign w_busy     = (r_state != S_IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Response in the capture cycle is taken directly; a flushed wait drains the orphan response
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_cap_load) begin
                    if (bus.DC_RValid) w_accept    = 1'b1;
                    else               w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.DC_RValid) begin
                    w_state_nxt = S_IDLE;
                    w_accept    = !bus.MEM2_Flush;
                end else if (bus.MEM2_Flush) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (bus.DC_RValid) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Flush clears load data only when no response is outstanding
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                               r_dmout <= '0;
        else if (w_accept)                         r_dmout <= bus.DC_RData;
        else if (bus.MEM2_Flush && !w_busy)        r_dmout <= '0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                           r_stall_cnt <= '0;
        else if (w_busy && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
    end

    assign bus.MEM2_ALUOut     = w_q.alu_out;
    assign bus.MEM2_PC         = w_q.pc;
    assign bus.MEM2_Instr      = w_q.instr;
    assign bus.MEM2_Dst        = w_q.dst;
    assign bus.MEM2_WbSel      = w_q.wb_sel;
    assign bus.MEM2_LoadType   = w_q.load_type;
    assign bus.MEM2_RegsWrType = w_q.regs_wr_type;
    assign bus.MEM2_OutB       = w_q.out_b;
    assign bus.MEM2_Result     = w_q.result;
    assign bus.MEM2_DMOut      = r_dmout;
    assign bus.MEM2_Stall_Req  = w_busy;
    assign bus.MEM2_StallCnt   = r_stall_cnt;

endmodule
